// File: rtl/out_pkt_arbiter_pkg.sv
// Shared definitions for the output packet arbiter: word width, defaults,
// FSM state encoding and the grant-index width helper.
package out_pkt_arbiter_pkg;

  localparam int WORD_W            = 16;
  localparam int CNT_W             = 16;
  localparam int DEF_N_SRC         = 4;
  localparam int DEF_MAX_PKT_WORDS = 1024;

  typedef logic [WORD_W-1:0] word_t;

  // FSM encoding kept as plain constants so the state register stays a plain vector
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Width of a source index; never narrower than one bit
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_pkt_arbiter_rr_select.sv
// Combinational round-robin search: picks the first requesting source
// strictly after `last`, wrapping, with `last` itself as lowest priority.
module rr_select
  import out_pkt_arbiter_pkg::*;
#(
  parameter  int N_SRC = DEF_N_SRC,
  localparam int GW    = sel_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    sel,
  output logic             any
);

  int   idx_s;
  logic hit_s;

  // Walk candidates from furthest to nearest so the nearest requester wins
  always_comb begin
    sel   = last;
    any   = 1'b0;
    idx_s = 0;
    hit_s = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx_s = (int'(last) + k) % N_SRC;
      hit_s = req[idx_s];
      sel   = hit_s ? GW'(idx_s) : sel;
      any   = any | hit_s;
    end
  end

endmodule

// File: rtl/out_pkt_arbiter.sv
// Output packet arbiter: grants one FWFT packet source at a time in
// round-robin order and streams its words into the output FIFO with
// zero-cycle pass-through. Over-long packets lock the block in ERR.
module out_pkt_arbiter
  import out_pkt_arbiter_pkg::*;
#(
  parameter  int N_SRC         = DEF_N_SRC,
  parameter  int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS,
  localparam int GW            = sel_w(N_SRC)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    enable,
  input  logic [N_SRC*WORD_W-1:0] src_dout,
  input  logic [N_SRC-1:0]        src_last,
  input  logic [N_SRC-1:0]        src_empty,
  output logic [N_SRC-1:0]        src_rd_en,
  output logic [WORD_W-1:0]       dout,
  output logic                    wr_en,
  input  logic                    full,
  output logic                    busy,
  output logic [GW-1:0]           grant,
  output logic                    err_pkt_len
);

  // A non-last word seen with the counter here means the packet is too long
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N_SRC-1:0] req_s;
  logic [GW-1:0]    rr_sel_s;
  logic             rr_any_s;
  logic             cur_empty_s;
  logic             cur_last_s;
  logic             xfer_s;
  word_t            src_word_s [N_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_split
      assign src_word_s[gi] = src_dout[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign req_s = ~src_empty;

  rr_select #(.N_SRC(N_SRC)) u_rr_select (
    .req  (req_s),
    .last (grant_q),
    .sel  (rr_sel_s),
    .any  (rr_any_s)
  );

  // Pick the granted source's flags/data and decide whether a word moves now
  always_comb begin
    cur_empty_s = src_empty[grant_q];
    cur_last_s  = src_last[grant_q];
    dout        = src_word_s[grant_q];
    xfer_s      = 1'b0;
    if (!RESET && (state_q == ST_XFER) && !cur_empty_s && !full) begin
      xfer_s = 1'b1;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Strobes: only the granted source is ever read, and only on a transfer
  always_comb begin
    src_rd_en = '0;
    wr_en     = xfer_s;
    if (xfer_s) begin
      src_rd_en[grant_q] = 1'b1;
    end else begin
      src_rd_en = '0;
    end
  end

  // Next-state logic for arbitration, packet tracking and length checking
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && rr_any_s) begin
          state_d = ST_XFER;
          grant_d = rr_sel_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (xfer_s) begin
          cnt_d = cnt_q + 16'd1;
          if (cur_last_s) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; grant parks on the last source
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      grant_q <= GW'(N_SRC - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q == ST_XFER);
  assign grant       = grant_q;
  assign err_pkt_len = err_q;

endmodule

// File: tb/tb_out_pkt_arbiter.sv
// Self-checking bench for out_pkt_arbiter: FWFT source queues, a
// packet-level reference model, directed scenarios and a random soak.
module tb_out_pkt_arbiter;

  localparam int N    = 4;
  localparam int MAXW = 8;
  localparam int GW   = 2;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              enable = 1'b0;
  logic [N*16-1:0]   src_dout = '0;
  logic [N-1:0]      src_last = '0;
  logic [N-1:0]      src_empty = '1;
  logic [N-1:0]      src_rd_en;
  logic [15:0]       dout;
  logic              wr_en;
  logic              full = 1'b0;
  logic              busy;
  logic [GW-1:0]     grant;
  logic              err_pkt_len;

  always #5 CLK = ~CLK;

  out_pkt_arbiter #(.N_SRC(N), .MAX_PKT_WORDS(MAXW)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable),
    .src_dout(src_dout), .src_last(src_last), .src_empty(src_empty),
    .src_rd_en(src_rd_en), .dout(dout), .wr_en(wr_en), .full(full),
    .busy(busy), .grant(grant), .err_pkt_len(err_pkt_len)
  );

  // Source contents: {last, word}; hold forces a source to look empty
  logic [16:0] srcq [N][$];
  logic [N-1:0] hold = '0;
  logic [15:0] wlog [$];

  int checks = 0;
  int errors = 0;

  // Reference model: packet in progress, granted source, words so far, error lock
  bit m_valid = 1'b0;
  bit m_busy  = 1'b0;
  bit m_err   = 1'b0;
  int m_grant = N - 1;
  int m_cnt   = 0;

  logic          obs_wr, obs_busy, obs_err;
  logic [15:0]   obs_dout;
  logic [N-1:0]  obs_rd;
  logic [GW-1:0] obs_grant;

  function automatic bit avail(int i);
    return (srcq[i].size() > 0) && !hold[i];
  endfunction

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic push_pkt(int s, int len, logic [15:0] base);
    for (int k = 0; k < len; k++) srcq[s].push_back({1'(k == len - 1), 16'(base + 16'(k))});
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (avail(i)) begin
        src_empty[i] = 1'b0;
        src_dout[i*16 +: 16] = srcq[i][0][15:0];
        src_last[i] = srcq[i][0][16];
      end else begin
        src_empty[i] = 1'b1;
        src_dout[i*16 +: 16] = 16'($urandom);
        src_last[i] = 1'($urandom);
      end
    end
  endtask

  // One clock: drive sources, sample at negedge+1, compare to model, advance
  task automatic step();
    bit           e_x;
    logic [16:0]  e_word;
    logic [N-1:0] e_rd;
    drive_src();
    #1;
    obs_wr = wr_en; obs_busy = busy; obs_err = err_pkt_len;
    obs_dout = dout; obs_rd = src_rd_en; obs_grant = grant;
    e_x = !RESET && m_busy && avail(m_grant) && !full;
    e_word = e_x ? srcq[m_grant][0] : 17'h0;
    e_rd = '0;
    if (e_x) e_rd[m_grant] = 1'b1;
    if (m_valid) begin
      checks++;
      if (obs_wr !== e_x) begin errors++; $display("FAIL model_wr_en: got %b expected %b", obs_wr, e_x); end
      checks++;
      if (obs_rd !== e_rd) begin errors++; $display("FAIL model_rd_en: got %b expected %b", obs_rd, e_rd); end
      checks++;
      if (obs_busy !== m_busy) begin errors++; $display("FAIL model_busy: got %b expected %b", obs_busy, m_busy); end
      checks++;
      if (obs_grant !== GW'(m_grant)) begin errors++; $display("FAIL model_grant: got %0d expected %0d", obs_grant, m_grant); end
      checks++;
      if (obs_err !== m_err) begin errors++; $display("FAIL model_err: got %b expected %b", obs_err, m_err); end
      if (e_x) begin
        checks++;
        if (obs_dout !== e_word[15:0]) begin errors++; $display("FAIL model_dout: got %h expected %h", obs_dout, e_word[15:0]); end
      end
    end
    if (obs_wr === 1'b1) wlog.push_back(obs_dout);
    for (int i = 0; i < N; i++) begin
      if (obs_rd[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    if (RESET) begin
      m_busy = 1'b0; m_err = 1'b0; m_grant = N - 1; m_cnt = 0; m_valid = 1'b1;
    end else if (m_err) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (enable) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && avail((m_grant + k) % N)) begin
            m_grant = (m_grant + k) % N; m_busy = 1'b1; m_cnt = 0;
          end
        end
      end
    end else if (e_x) begin
      m_cnt++;
      if (e_word[16]) m_busy = 1'b0;
      else if (m_cnt == MAXW) begin m_busy = 1'b0; m_err = 1'b1; end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; step(); step(); RESET = 1'b0;
  endtask

  task automatic test_reset();
    clear_srcs(); enable = 1'b1; full = 1'b0; hold = '0;
    RESET = 1'b1; step(); step();
    checks++; if (obs_grant !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d expected 3", obs_grant); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", obs_busy); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", obs_err); end
    checks++; if (obs_wr !== 1'b0 || obs_rd !== 4'b0) begin errors++; $display("FAIL reset_strobes: got wr %b rd %b expected 0", obs_wr, obs_rd); end
    RESET = 1'b0;
  endtask

  task automatic test_single_pkt();
    logic        exp_wr [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_d  [5]  = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    do_reset();
    srcq[1].push_back({1'b0, 16'h1111});
    srcq[1].push_back({1'b0, 16'h2222});
    srcq[1].push_back({1'b1, 16'h3333});
    for (int t = 0; t < 5; t++) begin
      step();
      checks++; if (obs_wr !== exp_wr[t] || obs_busy !== exp_wr[t]) begin errors++; $display("FAIL single_wr_busy t=%0d: got wr %b busy %b expected %b", t, obs_wr, obs_busy, exp_wr[t]); end
      if (exp_wr[t]) begin
        checks++; if (obs_dout !== exp_d[t]) begin errors++; $display("FAIL single_dout t=%0d: got %h expected %h", t, obs_dout, exp_d[t]); end
      end
      if (t > 0) begin
        checks++; if (obs_grant !== 2'd1) begin errors++; $display("FAIL single_grant t=%0d: got %0d expected 1", t, obs_grant); end
      end
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int s = 0; s < N; s++) begin
      push_pkt(s, 2, 16'(16'h1000 * (s + 1)));
      push_pkt(s, 2, 16'(16'h1000 * (s + 1) + 16'h0100));
    end
    for (int t = 0; t < 15; t++) begin
      step();
      checks++; if (obs_wr !== 1'((t % 3) != 0)) begin errors++; $display("FAIL rr_gap t=%0d: got wr %b expected %b", t, obs_wr, (t % 3) != 0); end
      if (t % 3 == 1) begin
        checks++; if (obs_grant !== GW'(order[t/3])) begin errors++; $display("FAIL rr_order pkt=%0d: got %0d expected %0d", t/3, obs_grant, order[t/3]); end
      end
    end
    clear_srcs();
  endtask

  task automatic test_full_stall();
    do_reset(); wlog.delete();
    push_pkt(0, 8, 16'h0A00);
    for (int t = 0; t < 20; t++) begin
      full = (t >= 3 && t < 8);
      step();
      if (t >= 3 && t < 8) begin
        checks++; if (obs_wr !== 1'b0 || obs_rd !== 4'b0) begin errors++; $display("FAIL stall_strobes t=%0d: got wr %b rd %b expected 0", t, obs_wr, obs_rd); end
      end
    end
    full = 1'b0;
    checks++; if (wlog.size() != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", wlog.size()); end
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      checks++; if (wlog[k] !== 16'(16'h0A00 + k)) begin errors++; $display("FAIL stall_word %0d: got %h expected %h", k, wlog[k], 16'h0A00 + k); end
    end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL stall_err: got %b expected 0", obs_err); end
  endtask

  task automatic test_enable_drop();
    do_reset(); wlog.delete(); enable = 1'b1;
    push_pkt(0, 4, 16'hB000);
    push_pkt(2, 1, 16'hC000);
    step(); step();
    enable = 1'b0;
    for (int t = 2; t < 10; t++) begin
      step();
      if (t >= 5) begin
        checks++; if (obs_busy !== 1'b0 || obs_wr !== 1'b0 || obs_grant !== 2'd0) begin errors++; $display("FAIL endrop_idle t=%0d: got busy %b wr %b grant %0d expected 0 0 0", t, obs_busy, obs_wr, obs_grant); end
      end
    end
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL endrop_count: got %0d expected 4", wlog.size()); end
    enable = 1'b1;
    step(); step();
    checks++; if (obs_grant !== 2'd2 || obs_wr !== 1'b1 || obs_dout !== 16'hC000) begin errors++; $display("FAIL endrop_regrant: got grant %0d wr %b dout %h expected 2 1 c000", obs_grant, obs_wr, obs_dout); end
    clear_srcs();
  endtask

  task automatic test_max_len();
    do_reset(); wlog.delete();
    push_pkt(0, 9, 16'hD000);
    for (int t = 0; t < 15; t++) begin
      step();
      if (t == 8) begin
        checks++; if (obs_wr !== 1'b1 || obs_err !== 1'b0) begin errors++; $display("FAIL maxlen_8th t=8: got wr %b err %b expected 1 0", obs_wr, obs_err); end
      end
      if (t >= 9) begin
        checks++; if (obs_err !== 1'b1 || obs_wr !== 1'b0 || obs_rd !== 4'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL maxlen_err t=%0d: got err %b wr %b rd %b busy %b expected 1 0 0 0", t, obs_err, obs_wr, obs_rd, obs_busy); end
      end
    end
    checks++; if (wlog.size() != 8 || srcq[0].size() != 1) begin errors++; $display("FAIL maxlen_words: got written %0d left %0d expected 8 1", wlog.size(), srcq[0].size()); end
    clear_srcs();
    RESET = 1'b1; step(); step();
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL maxlen_clear: got %b expected 0", obs_err); end
    RESET = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_pkt(1, 3, 16'hE000);
    step(); step();
    RESET = 1'b1;
    step();
    checks++; if (obs_wr !== 1'b0 || obs_rd !== 4'b0) begin errors++; $display("FAIL rstmid_strobes: got wr %b rd %b expected 0", obs_wr, obs_rd); end
    step();
    checks++; if (obs_grant !== 2'd3 || obs_busy !== 1'b0) begin errors++; $display("FAIL rstmid_grant: got grant %0d busy %b expected 3 0", obs_grant, obs_busy); end
    push_pkt(0, 2, 16'h5A00);
    RESET = 1'b0;
    step(); step();
    checks++; if (obs_grant !== 2'd0 || obs_wr !== 1'b1 || obs_dout !== 16'h5A00) begin errors++; $display("FAIL rstmid_first: got grant %0d wr %b dout %h expected 0 1 5a00", obs_grant, obs_wr, obs_dout); end
    for (int t = 0; t < 8; t++) step();
    checks++; if (srcq[1].size() != 0 || srcq[0].size() != 0) begin errors++; $display("FAIL rstmid_drain: got left %0d %0d expected 0 0", srcq[0].size(), srcq[1].size()); end
    clear_srcs();
  endtask

  task automatic test_random();
    int err_cycles = 0;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(0, 9) < 3)
          push_pkt(i, $urandom_range(1, 10), 16'($urandom));
        hold[i] = ($urandom_range(0, 9) < 2);
      end
      full   = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 9) != 0);
      err_cycles = m_err ? err_cycles + 1 : 0;
      RESET  = (err_cycles > 3) || ($urandom_range(0, 199) == 0);
      step();
    end
    RESET = 1'b0; hold = '0; full = 1'b0;
    clear_srcs();
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_full_stall();
    test_enable_drop();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_pkt_arbiter.md
OUT_PKT_ARBITER -- requirements
Module: out_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, giving the number of packet sources sharing the output FIFO write port.
REQ-002 The block SHALL have parameter MAX_PKT_WORDS, default 1024, giving the maximum packet length in 16-bit words.
REQ-003 The block SHALL have port CLK, input, 1, single clock, the PKT_COMM_CLK domain; all logic SHALL be on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1, grant-enable driven from app_mode.
REQ-006 The block SHALL have port src_dout, input, N_SRC*16, per-source first-word-fall-through (FWFT) data; source i occupies bits [16i+15:16i].
REQ-007 The block SHALL have port src_last, input, N_SRC, per-source flag marking the presented word as the packet's last word.
REQ-008 The block SHALL have port src_empty, input, N_SRC, per-source "no word presented" flag.
REQ-009 The block SHALL have port src_rd_en, output, N_SRC, per-source word-consume strobe.
REQ-010 The block SHALL have port dout, output, 16, data to the output FIFO din.
REQ-011 The block SHALL have port wr_en, output, 1, output FIFO write strobe.
REQ-012 The block SHALL have port full, input, 1, output FIFO full.
REQ-013 The block SHALL have port busy, output, 1, high while a packet is in transfer.
REQ-014 The block SHALL have port grant, output, 2 (log2 N_SRC), index of the current or last granted source.
REQ-015 The block SHALL have port err_pkt_len, output, 1, sticky flag set when a packet exceeds MAX_PKT_WORDS.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, XFER and ERR.
REQ-017 In IDLE with enable=1 and any src_empty[i]=0, the block SHALL select the first non-empty source in round-robin order, starting at grant+1 and wrapping modulo N_SRC, and SHALL register it into grant and enter XFER on the next edge; this arbitration latency SHALL be 1 cycle.
REQ-018 In IDLE with enable=0, or with all sources empty, the block SHALL remain in IDLE and grant SHALL hold its value.
REQ-019 In XFER, a word SHALL transfer in a cycle iff src_empty[grant]=0 and full=0; in that cycle src_rd_en[grant]=1 and wr_en=1.
REQ-020 During a transfer cycle, dout SHALL equal the src_dout slice of grant combinationally, giving zero-cycle pass-through.
REQ-021 Outside a transfer cycle, wr_en and all src_rd_en bits SHALL be 0, and only the granted source's src_rd_en SHALL ever assert.
REQ-022 A 16-bit word counter SHALL clear on entry to XFER and SHALL increment on each transferred word.
REQ-023 A transferred word with src_last[grant]=1 SHALL end the packet; the FSM SHALL return to IDLE, and a new grant SHALL be issued no earlier than the following cycle, giving a minimum 1-cycle gap.
REQ-024 When a non-last word is transferred with the counter at MAX_PKT_WORDS-1, the FSM SHALL enter ERR and set err_pkt_len.
REQ-025 ERR SHALL be terminal until RESET: no rd_en, no wr_en, busy=0.
REQ-026 Dropping enable during XFER SHALL NOT abort the packet; the transfer SHALL complete through its last word, and no new grant SHALL follow while enable=0.
REQ-027 full=1 and src_empty[grant]=1 SHALL each stall the transfer indefinitely, with no timeout; counter and state SHALL hold.
REQ-028 When full deasserts in the same cycle that a source becomes non-empty, the transfer SHALL occur in that cycle.
REQ-029 Non-granted sources SHALL never be read, regardless of their flags.
REQ-030 busy SHALL equal (state==XFER).

Reset
REQ-031 On RESET=1, the block SHALL set state to IDLE, grant to N_SRC-1 (so source 0 wins first), counter to 0 and err_pkt_len to 0, and SHALL drive wr_en=0 and src_rd_en=0 in the same cycle.
REQ-032 RESET asserted mid-packet SHALL abandon the packet immediately; residual words stay in the source, and recovery of a partially transferred packet is the upstream's responsibility.

Structure
REQ-033 The state encoding, N_SRC, MAX_PKT_WORDS defaults and the word-width constant (16) SHALL reside in the shared definitions.vh global include.
REQ-034 The round-robin search SHALL be a separate combinational sub-module, rr_select, with inputs req[N_SRC] and last[log2 N_SRC] and outputs sel[log2 N_SRC] and any.
REQ-035 The total implementation SHALL be 120-400 lines of RTL; the datapath mux SHALL be sized by N_SRC.

Verification
REQ-036 Bench SHALL drive source 1 with a 3-word packet 0x1111/0x2222/0x3333 (last on the third word), all others empty, full=0 -> grant=1 one cycle after the request, wr_en high for 3 consecutive cycles with dout in order, then busy=0.
REQ-037 Bench SHALL drive all 4 sources continuously with 2-word packets from reset -> grant order 0,1,2,3,0, with 2 writes per packet and a 1-cycle gap between packets.
REQ-038 Bench SHALL assert full for 5 cycles mid-packet -> wr_en=0 and src_rd_en=0 for those 5 cycles, with no words lost or duplicated and the counter unchanged.
REQ-039 Bench SHALL deassert enable after the first of 4 words -> the remaining 3 words are written, then no grant is issued although source 2 is non-empty; re-enabling it -> grant=2.
REQ-040 Bench SHALL run with MAX_PKT_WORDS=8 and a 9-word packet -> err_pkt_len=1 after the 8th write, the 9th word is not read, and the block stays in ERR until RESET, after which err_pkt_len=0.
REQ-041 Bench SHALL assert RESET during the 2nd word of a packet -> wr_en=0 in the reset cycle, grant=3 after reset, and source 0 is served first.
